// File: rtl/his_acq_sequencer_pkg.sv
// Shared definitions for the histogram acquisition sequencer: default
// geometry, FSM state encoding and a counter-width helper.
package his_acq_sequencer_pkg;

    localparam int unsigned DEF_DATA_NUM  = 2;
    localparam int unsigned DEF_PIXEL_NUM = 200;
    localparam int unsigned DEF_ACQ_NUM   = 33333;
    localparam int unsigned DEF_ADDR_W    = 8;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StClear  = 3'd1,
        StCount  = 3'd2,
        StPixAdv = 3'd3,
        StAcqAdv = 3'd4,
        StSwap   = 3'd5,
        StWaitRd = 3'd6
    } his_state_e;

    // Width of a counter holding 0..n-1; never below one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/his_bank_clear.sv
// Bank clear sweep: on a start pulse, emits one clear write per cycle for
// every bin address 0..2**ADDR_W-1 and flags the final address with done.
module his_bank_clear #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              res,
    input  logic              start,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              done
);

    logic              active_q;
    logic [ADDR_W-1:0] addr_q;
    logic              last;

    assign last = (addr_q == {ADDR_W{1'b1}});

    // Sweep register: arm on start, step once per cycle, drop after last bin.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            active_q <= 1'b0;
            addr_q   <= '0;
        end else if (start) begin
            active_q <= 1'b1;
            addr_q   <= '0;
        end else if (active_q) begin
            active_q <= !last;
            addr_q   <= last ? '0 : addr_q + 1'b1;
        end
    end

    assign clr_en   = active_q;
    assign clr_addr = addr_q;
    assign done     = active_q & last;

endmodule

// File: rtl/his_acq_sequencer.sv
// Frame-level controller for the ping-pong histogram banks: clears the bank
// being built, accepts TDC timestamps, counts data/pixel/acquisition slots,
// swaps banks at frame end and hands the finished bank to readout.
module his_acq_sequencer
    import his_acq_sequencer_pkg::*;
#(
    parameter int unsigned DATA_NUM  = DEF_DATA_NUM,
    parameter int unsigned PIXEL_NUM = DEF_PIXEL_NUM,
    parameter int unsigned ACQ_NUM   = DEF_ACQ_NUM,
    parameter int unsigned ADDR_W    = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              res,
    input  logic              run,
    input  logic              tdc_valid,
    output logic              tdc_ready,
    output logic              wr_en,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              bank_sel,
    output logic [7:0]        pixel_idx,
    output logic              frame_done,
    output logic              rd_req,
    input  logic              rd_ack,
    output logic              busy
);

    localparam int unsigned IN_W  = cnt_w(DATA_NUM);
    localparam int unsigned ACQ_W = cnt_w(ACQ_NUM);

    localparam logic [IN_W-1:0]  IN_LAST  = IN_W'(DATA_NUM - 1);
    localparam logic [7:0]       PIX_LAST = 8'(PIXEL_NUM - 1);
    localparam logic [ACQ_W-1:0] ACQ_LAST = ACQ_W'(ACQ_NUM - 1);

    his_state_e       state_q, state_d;
    logic [IN_W-1:0]  in_cnt_q;
    logic [7:0]       pix_q;
    logic [ACQ_W-1:0] acq_q;
    logic             bank_q;
    logic             rd_req_q;
    logic             wr_en_q;

    logic hs;
    logic in_last;
    logic pix_last;
    logic acq_last;
    logic swap_fire;
    logic clr_start;
    logic clr_done;

    assign hs       = tdc_valid & tdc_ready;
    assign in_last  = (in_cnt_q == IN_LAST);
    assign pix_last = (pix_q == PIX_LAST);
    assign acq_last = (acq_q == ACQ_LAST);

    // A pending readout blocks the swap unless it is acknowledged this same cycle.
    assign swap_fire = ((state_q == StSwap) && (!rd_req_q || rd_ack)) ||
                       ((state_q == StWaitRd) && rd_ack);

    // Kick the sweep on every entry into CLEAR (from IDLE or straight after a swap).
    assign clr_start = (state_d == StClear) && (state_q != StClear);

    his_bank_clear #(
        .ADDR_W (ADDR_W)
    ) u_bank_clear (
        .clk      (clk),
        .res      (res),
        .start    (clr_start),
        .clr_en   (clr_en),
        .clr_addr (clr_addr),
        .done     (clr_done)
    );

    // State register.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (run) state_d = StClear;
            StClear:  if (clr_done) state_d = StCount;
            StCount:  if (hs && in_last) state_d = StPixAdv;
            StPixAdv: state_d = pix_last ? StAcqAdv : StCount;
            StAcqAdv: state_d = acq_last ? StSwap : StCount;
            StSwap, StWaitRd: begin
                if (swap_fire) begin
                    state_d = run ? StClear : StIdle;
                end else begin
                    state_d = StWaitRd;
                end
            end
            default:  state_d = StIdle;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        tdc_ready  = (state_q == StCount);
        frame_done = swap_fire;
        busy       = (state_q != StIdle);
    end

    // Slot counters: data per pixel, pixel per acquisition, acquisition per frame.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            in_cnt_q <= '0;
            pix_q    <= '0;
            acq_q    <= '0;
        end else begin
            if (hs) begin
                in_cnt_q <= in_last ? '0 : in_cnt_q + 1'b1;
            end
            if (state_q == StPixAdv) begin
                pix_q <= pix_last ? '0 : pix_q + 1'b1;
            end
            if (state_q == StAcqAdv) begin
                acq_q <= acq_last ? '0 : acq_q + 1'b1;
            end
        end
    end

    // Bank select, readout request and the one-cycle-late increment strobe.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            bank_q   <= 1'b0;
            rd_req_q <= 1'b0;
            wr_en_q  <= 1'b0;
        end else begin
            wr_en_q <= hs;
            if (swap_fire) begin
                bank_q   <= ~bank_q;
                rd_req_q <= 1'b1;
            end else if (rd_ack) begin
                rd_req_q <= 1'b0;
            end
        end
    end

    assign wr_en     = wr_en_q;
    assign bank_sel  = bank_q;
    assign rd_req    = rd_req_q;
    assign pixel_idx = pix_q;

endmodule

// File: tb/tb_his_acq_sequencer.sv
// Randomized scenario bench for his_acq_sequencer with a small frame geometry.
module tb_his_acq_sequencer;

    localparam int unsigned DATA_NUM  = 2;
    localparam int unsigned PIXEL_NUM = 3;
    localparam int unsigned ACQ_NUM   = 2;
    localparam int unsigned ADDR_W    = 3;
    localparam int FRAME_LEN = int'(DATA_NUM * PIXEL_NUM * ACQ_NUM);
    localparam int CLR_LEN   = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              res, run, tdc_valid, rd_ack;
    logic              tdc_ready, wr_en, clr_en, bank_sel, frame_done, rd_req, busy;
    logic [ADDR_W-1:0] clr_addr;
    logic [7:0]        pixel_idx;
    logic [17:0]       outs;

    int checks = 0;
    int errors = 0;

    // Model state: pixel of every accepted timestamp, strobe and swap tallies.
    int hs_pix[$];
    int wr_cnt  = 0;
    int fd_cnt  = 0;
    int lat_bad = 0;
    bit prev_hs = 1'b0;
    bit exp_bank   = 1'b0;
    bit exp_rdreq  = 1'b0;

    his_acq_sequencer #(
        .DATA_NUM  (DATA_NUM),
        .PIXEL_NUM (PIXEL_NUM),
        .ACQ_NUM   (ACQ_NUM),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk        (clk),
        .res        (res),
        .run        (run),
        .tdc_valid  (tdc_valid),
        .tdc_ready  (tdc_ready),
        .wr_en      (wr_en),
        .clr_en     (clr_en),
        .clr_addr   (clr_addr),
        .bank_sel   (bank_sel),
        .pixel_idx  (pixel_idx),
        .frame_done (frame_done),
        .rd_req     (rd_req),
        .rd_ack     (rd_ack),
        .busy       (busy)
    );

    assign outs = {tdc_ready, wr_en, clr_en, clr_addr, bank_sel, pixel_idx,
                   frame_done, rd_req, busy};

    always #5 clk = ~clk;

    // Observe the cycle's stable values in mid-cycle.
    always @(negedge clk) begin
        if (res) begin
            if (tdc_valid && tdc_ready) hs_pix.push_back(int'(pixel_idx));
            if (wr_en) wr_cnt++;
            if (frame_done) fd_cnt++;
            if (wr_en !== prev_hs) lat_bad++;
            prev_hs = tdc_valid && tdc_ready;
        end else begin
            prev_hs = 1'b0;
        end
    end

    // Pixel slot that the k-th accepted timestamp of a frame belongs to.
    function automatic int exp_pixel(input int k);
        return (k / int'(DATA_NUM)) % int'(PIXEL_NUM);
    endfunction

    task automatic drive_edge;
        @(posedge clk);
        #1;
    endtask

    task automatic sample_edge;
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset;
        sample_edge;
        checks++;
        if (outs !== 18'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", outs);
        end
        drive_edge;
        res = 1'b1;
        sample_edge;
        checks++;
        if (outs !== 18'd0) begin
            errors++;
            $display("FAIL idle_outputs: got %h want 0", outs);
        end
    endtask

    // Waits for a bank clear, checks the full sweep, then the hand-over to COUNT.
    task automatic test_clear(input bit ack_first);
        int guard;
        hs_pix.delete();
        wr_cnt  = 0;
        fd_cnt  = 0;
        lat_bad = 0;
        guard   = 0;
        do begin
            drive_edge;
            tdc_valid = 1'($urandom_range(0, 1));
            rd_ack    = (guard == 0) ? ack_first : 1'b0;
            sample_edge;
            guard++;
        end while (clr_en !== 1'b1 && guard < 20);
        if (ack_first) exp_rdreq = 1'b0;
        checks++;
        if (clr_en !== 1'b1) begin
            errors++;
            $display("FAIL clear_start: clr_en got %b want 1 within 20 cycles", clr_en);
        end else begin
            for (int a = 0; a < CLR_LEN; a++) begin
                if (a > 0) begin
                    drive_edge;
                    tdc_valid = 1'($urandom_range(0, 1));
                    rd_ack    = 1'b0;
                    sample_edge;
                end
                checks++;
                if (clr_en !== 1'b1 || clr_addr !== ADDR_W'(a)) begin
                    errors++;
                    $display("FAIL clear_sweep: got en=%b addr=%0d want en=1 addr=%0d",
                             clr_en, clr_addr, a);
                end
            end
        end
        drive_edge;
        tdc_valid = 1'b0;
        rd_ack    = 1'b0;
        sample_edge;
        checks++;
        if ({clr_en, tdc_ready, busy} !== 3'b011) begin
            errors++;
            $display("FAIL clear_exit: got clr_en/ready/busy=%b want 011",
                     {clr_en, tdc_ready, busy});
        end
        checks++;
        if (bank_sel !== exp_bank || rd_req !== exp_rdreq) begin
            errors++;
            $display("FAIL bank_state: got bank=%b rd_req=%b want bank=%b rd_req=%b",
                     bank_sel, rd_req, exp_bank, exp_rdreq);
        end
        checks++;
        if (hs_pix.size() != 0) begin
            errors++;
            $display("FAIL clear_no_accept: got %0d accepts want 0", hs_pix.size());
        end
    endtask

    // Random-valid stream until n timestamps of this frame have been accepted.
    task automatic stream(input int n_hs);
        int guard;
        guard = 0;
        while (hs_pix.size() < n_hs && guard < 400) begin
            drive_edge;
            tdc_valid = ($urandom_range(0, 3) != 0);
            rd_ack    = 1'b0;
            sample_edge;
            guard++;
        end
        checks++;
        if (hs_pix.size() != n_hs) begin
            errors++;
            $display("FAIL stream_accept: got %0d want %0d", hs_pix.size(), n_hs);
        end
    endtask

    task automatic wait_frame_done;
        int guard;
        guard = 0;
        do begin
            drive_edge;
            tdc_valid = 1'($urandom_range(0, 1));
            rd_ack    = 1'b0;
            sample_edge;
            guard++;
        end while (frame_done !== 1'b1 && guard < 20);
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL frame_done_timeout: frame_done got %b want 1", frame_done);
        end else begin
            exp_bank  = ~exp_bank;
            exp_rdreq = 1'b1;
        end
    endtask

    task automatic check_frame_content;
        for (int k = 0; k < hs_pix.size(); k++) begin
            checks++;
            if (hs_pix[k] != exp_pixel(k)) begin
                errors++;
                $display("FAIL pixel_seq[%0d]: got %0d want %0d", k, hs_pix[k], exp_pixel(k));
            end
        end
        checks++;
        if (wr_cnt != FRAME_LEN || lat_bad != 0) begin
            errors++;
            $display("FAIL wr_strobes: got %0d (late/stray %0d) want %0d (0)",
                     wr_cnt, lat_bad, FRAME_LEN);
        end
        checks++;
        if (fd_cnt != 1) begin
            errors++;
            $display("FAIL frame_done_count: got %0d want 1", fd_cnt);
        end
    endtask

    task automatic test_first_frame;
        drive_edge;
        run = 1'b1;
        test_clear(1'b0);
        stream(FRAME_LEN);
        wait_frame_done;
        check_frame_content;
    endtask

    // Second frame without readout ack stalls until rd_ack arrives.
    task automatic test_wait_rd;
        test_clear(1'b0);
        stream(FRAME_LEN);
        for (int i = 0; i < 6; i++) begin
            drive_edge;
            tdc_valid = 1'b1;
            rd_ack    = 1'b0;
            sample_edge;
        end
        checks++;
        if (fd_cnt != 0 || tdc_ready !== 1'b0 || busy !== 1'b1 || bank_sel !== exp_bank) begin
            errors++;
            $display("FAIL wait_rd_hold: got fd=%0d ready=%b busy=%b bank=%b want 0 0 1 %b",
                     fd_cnt, tdc_ready, busy, bank_sel, exp_bank);
        end
        checks++;
        if (hs_pix.size() != FRAME_LEN || wr_cnt != FRAME_LEN) begin
            errors++;
            $display("FAIL wait_rd_no_write: got accepts=%0d writes=%0d want %0d",
                     hs_pix.size(), wr_cnt, FRAME_LEN);
        end
        drive_edge;
        tdc_valid = 1'b0;
        rd_ack    = 1'b1;
        sample_edge;
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL wait_rd_release: frame_done got %b want 1", frame_done);
        end
        exp_bank  = ~exp_bank;
        exp_rdreq = 1'b1;
    endtask

    // Ack lands exactly on the SWAP cycle: last accept + PIX_ADV + ACQ_ADV + SWAP.
    task automatic test_ack_on_swap;
        test_clear(1'b0);
        stream(FRAME_LEN);
        drive_edge;
        tdc_valid = 1'b0;
        drive_edge;
        drive_edge;
        rd_ack = 1'b1;
        sample_edge;
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL ack_on_swap: frame_done got %b want 1", frame_done);
        end
        exp_bank  = ~exp_bank;
        exp_rdreq = 1'b1;
        check_frame_content;
    endtask

    task automatic test_run_stop;
        int seen;
        test_clear(1'b1);
        stream(DATA_NUM);
        drive_edge;
        run       = 1'b0;
        tdc_valid = 1'b0;
        sample_edge;
        stream(FRAME_LEN);
        wait_frame_done;
        check_frame_content;
        drive_edge;
        tdc_valid = 1'b1;
        sample_edge;
        checks++;
        if (busy !== 1'b0 || tdc_ready !== 1'b0 || bank_sel !== exp_bank || rd_req !== exp_rdreq)
        begin
            errors++;
            $display("FAIL run_stop_idle: got busy=%b ready=%b bank=%b rd_req=%b want 0 0 %b %b",
                     busy, tdc_ready, bank_sel, rd_req, exp_bank, exp_rdreq);
        end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            drive_edge;
            sample_edge;
            if (clr_en || busy || tdc_ready) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL run_stop_stays_idle: got %0d active cycles want 0", seen);
        end
    endtask

    task automatic test_reset_mid;
        drive_edge;
        run       = 1'b1;
        tdc_valid = 1'b0;
        test_clear(1'b0);
        stream($urandom_range(1, FRAME_LEN - 2));
        drive_edge;
        res = 1'b0;
        #1;
        checks++;
        if (outs !== 18'd0) begin
            errors++;
            $display("FAIL reset_abort: got %h want 0", outs);
        end
        exp_bank  = 1'b0;
        exp_rdreq = 1'b0;
        drive_edge;
        res = 1'b1;
        test_clear(1'b0);
        stream(FRAME_LEN);
        wait_frame_done;
        check_frame_content;
        test_clear(1'b0);
    endtask

    initial begin
        res       = 1'b0;
        run       = 1'b0;
        tdc_valid = 1'b0;
        rd_ack    = 1'b0;
        repeat (3) @(posedge clk);
        test_reset;
        test_first_frame;
        test_wait_rd;
        test_ack_on_swap;
        test_run_stop;
        test_reset_mid;
        drive_edge;
        run = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d",
                 checks, errors);
        $fatal(1);
    end

endmodule
